// File: rtl/delay_timer_pkg.sv
// Shared definitions for the delay timer scheduler.
// Contents: FSM state encoding, default parameter values, and the helper
// that sizes requester index fields.
package delay_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_CNT_W    = 30;
  localparam int DEF_PRESCALE = 100000000;

  // Index width for n requesters. It never goes below 1, so that a
  // 2-requester build still gets a real index bit.
  function automatic int id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The lowest-index request at or after ptr_i wins. The search wraps from
// N_REQ-1 back to 0.
// Ports:
//   req_i   [N_REQ-1:0]  request vector
//   ptr_i   [ID_W-1:0]   priority pointer (highest-priority index)
//   gnt_o   [N_REQ-1:0]  one-hot winner (zero when no request)
//   idx_o   [ID_W-1:0]   winner index
//   valid_o              any request present
module rr_arbiter
  import delay_timer_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = id_w(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             valid_o
);

  int pos;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      if (!valid_o && req_i[pos]) begin
        valid_o    = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/delay_timer_scheduler.sv
// Shares one down-counting delay timer among N_REQ requesters.
// Requests are granted round-robin. The owner's length is loaded when the
// grant is issued, and done pulses to that owner when the count expires.
// Optional feature macro: PRESCALE_EN.
//   Defined:   the counter only steps on a prescaler tick, which comes once
//              every PRESCALE clocks.
//   Undefined: the counter steps every clock.
// Ports:
//   clk    system clock (posedge)
//   rst    asynchronous active-low reset
//   req    [N_REQ-1:0]        request levels
//   len    [N_REQ*CNT_W-1:0]  packed delay lengths, slice i = requester i
//   grant  [N_REQ-1:0]        one-hot 1-cycle grant pulse
//   done   [N_REQ-1:0]        one-hot 1-cycle expiry pulse
//   busy                      timer owned (GRANT/COUNT/DONE)
//   owner  [ID_W-1:0]         current owner index
module delay_timer_scheduler
  import delay_timer_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int CNT_W = DEF_CNT_W
`ifdef PRESCALE_EN
  , parameter int PRESCALE = DEF_PRESCALE
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*CNT_W-1:0]   len,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic [id_w(N_REQ)-1:0]   owner
);

  localparam int ID_W = id_w(N_REQ);

  state_e             state_q;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   done_q;
  logic               busy_q;
  logic [ID_W-1:0]    owner_q;
  logic [ID_W-1:0]    ptr_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [N_REQ-1:0]   win_oh_s;
  logic [ID_W-1:0]    win_idx_s;
  logic               win_valid_s;
  logic               tick_s;
  logic [CNT_W-1:0]   len_sel_s;
  logic [N_REQ-1:0]   owner_oh_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (win_oh_s),
    .idx_o   (win_idx_s),
    .valid_o (win_valid_s)
  );

  // owner_q is already latched by the GRANT cycle, so it selects the
  // length slice that gets loaded there.
  assign len_sel_s  = len[int'(owner_q)*CNT_W +: CNT_W];
  assign owner_oh_s = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;

`ifdef PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PS_W-1:0] presc_q;

  assign tick_s = (presc_q == PS_W'(PRESCALE - 1));

  // The prescaler is cleared in GRANT. This makes the first tick land
  // exactly PRESCALE cycles after the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (state_q == GRANT) begin
      presc_q <= '0;
    end else if (state_q == COUNT) begin
      presc_q <= tick_s ? '0 : presc_q + PS_W'(1);
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q  <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          if (win_valid_s) begin
            state_q <= GRANT;
            owner_q <= win_idx_s;
            grant_q <= win_oh_s;
            busy_q  <= 1'b1;
          end
        end
        GRANT: begin
          grant_q <= '0;
          cnt_q   <= len_sel_s;
          state_q <= COUNT;
        end
        COUNT: begin
          // Zero is checked before decrementing. A length of len therefore
          // takes len+1 ticks, and the counter never wraps.
          if (tick_s) begin
            if (cnt_q == '0) begin
              state_q <= DONE;
              done_q  <= owner_oh_s;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
        end
        DONE: begin
          done_q  <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + ID_W'(1);
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_delay_timer_scheduler.sv
// Directed testbench for delay_timer_scheduler (N_REQ=4, CNT_W=30).
// Default build: single grant latency, in-order service, fairness, len=0,
// and reset during COUNT.
// PRESCALE_EN build: prescaled latency with PRESCALE=4.
module tb_delay_timer_scheduler;

  localparam int N = 4;
  localparam int W = 30;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] len;
  logic [N-1:0]   grant;
  logic [N-1:0]   done;
  logic           busy;
  logic [1:0]     owner;

  int checks;
  int errors;

`ifdef PRESCALE_EN
  delay_timer_scheduler #(.N_REQ(N), .CNT_W(W), .PRESCALE(4)) dut (
`else
  delay_timer_scheduler #(.N_REQ(N), .CNT_W(W)) dut (
`endif
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .len   (len),
    .grant (grant),
    .done  (done),
    .busy  (busy),
    .owner (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  // Wait for the grant to idx, then for its done. Check the gap to the
  // grant, the latency from grant to done, and that owner/busy stay stable
  // with no stray grant in between.
  task automatic serve(input int idx, input int exp_gap, input int exp_lat, input bit drop);
    int n;
    int bad;
    logic [N-1:0] one;
    logic [N-1:0] m;
    one = 4'b0001;
    m   = one << idx;
    n   = 0;
    do begin
      step();
      n++;
    end while (grant == '0 && n < 60);
    chk("grant_gap", n, exp_gap);
    chk("grant_mask", grant, m);
    chk("grant_owner", owner, idx);
    chk("grant_busy", busy, 1);
    chk("grant_nodone", done, 0);
    if (drop) req[idx] = 1'b0;
    n   = 0;
    bad = 0;
    do begin
      step();
      n++;
      if (grant !== '0 || owner !== idx[1:0] || busy !== 1'b1) bad++;
    end while (done == '0 && n < 200);
    chk("done_lat", n, exp_lat);
    chk("done_mask", done, m);
    chk("hold_owner_busy", bad, 0);
  endtask

  initial begin
    int cnt;
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    req    = '0;
    len    = '0;
    #2;
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    step();
    rst = 1'b1;
    step();

`ifdef PRESCALE_EN
    // Prescaled: done arrives (len+1)*PRESCALE+1 = 17 cycles after grant.
    req = 4'b0001;
    len[0*W +: W] = 30'd3;
    serve(0, 1, 17, 1'b1);
    step();
    chk("ps_busy_after", busy, 0);
`else
    // Test 1: single request, len=5, so done arrives grant+7.
    req = 4'b0001;
    len[0*W +: W] = 30'd5;
    serve(0, 1, 7, 1'b1);
    step();
    chk("t1_busy_after", busy, 0);
    chk("t1_done_after", done, 0);

    // Test 2: all four request with len=2 from pointer 0.
    do_reset();
    len[0*W +: W] = 30'd2;
    len[1*W +: W] = 30'd2;
    len[2*W +: W] = 30'd2;
    len[3*W +: W] = 30'd2;
    req = 4'b1111;
    serve(0, 1, 4, 1'b1);
    serve(1, 2, 4, 1'b1);
    serve(2, 2, 4, 1'b1);
    serve(3, 2, 4, 1'b1);

    // Test 3: req 0 and 2 held continuously, then req 1 joins.
    len[0*W +: W] = 30'd3;
    len[2*W +: W] = 30'd1;
    len[1*W +: W] = 30'd4;
    req = 4'b0101;
    serve(0, 2, 5, 1'b0);
    serve(2, 2, 3, 1'b0);
    req[1] = 1'b1;
    serve(0, 2, 5, 1'b1);
    serve(1, 2, 6, 1'b1);
    serve(2, 2, 3, 1'b1);

    // Test 4: len=0 on requester 3, so done arrives two cycles after grant.
    step();
    len[3*W +: W] = 30'd0;
    req = 4'b1000;
    serve(3, 1, 2, 1'b1);

    // Test 5: reset asserted mid-count aborts the delay with no done pulse.
    do_reset();
    len[1*W +: W] = 30'd100;
    req = 4'b0010;
    step();
    chk("t5_grant", grant, 4'b0010);
    req = '0;
    repeat (40) step();
    chk("t5_busy_mid", busy, 1);
    chk("t5_owner_mid", owner, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_owner", owner, 0);
    step();
    step();
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 130; i++) begin
      step();
      if (done !== '0 || busy !== 1'b0) cnt++;
    end
    chk("t5_no_done", cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
